// File: rtl/cfs_algn_pkg.sv
// Shared aligner definitions: field widths, FIFO entry layout and the
// byte-window legality rule used by both the TX and RX controllers.
package cfs_algn_pkg;

  function automatic int offset_width(input int data_width);
    return (data_width <= 8) ? 1 : $clog2(data_width / 8);
  endfunction

  function automatic int size_width(input int data_width);
    return $clog2(data_width / 8) + 1;
  endfunction

  function automatic int fifo_width(input int data_width);
    return data_width + offset_width(data_width) + size_width(data_width);
  endfunction

  // Entry layout, LSB first: {size, offset, data}
  function automatic int data_lsb(input int data_width);
    return 0;
  endfunction

  function automatic int data_msb(input int data_width);
    return data_width - 1;
  endfunction

  function automatic int offset_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int offset_msb(input int data_width);
    return data_width + offset_width(data_width) - 1;
  endfunction

  function automatic int size_lsb(input int data_width);
    return offset_msb(data_width) + 1;
  endfunction

  function automatic int size_msb(input int data_width);
    return fifo_width(data_width) - 1;
  endfunction

  // end_byte is offset+size, computed by the caller one bit wider than size
  function automatic bit entry_legal(input int unsigned size,
                                     input int unsigned end_byte,
                                     input int unsigned bytes);
    return (size != 0) && (end_byte <= bytes);
  endfunction

endpackage

// File: rtl/cfs_sat_cnt.sv
// Saturating up-counter; a synchronous clear takes priority over an increment.
module cfs_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/cfs_md_tx_ctrl.sv
// TX FIFO to MD master bridge: two-entry output buffer (output + skid register),
// drops illegal entries, and keeps saturating transfer/error/drop statistics.
module cfs_md_tx_ctrl
  import cfs_algn_pkg::*;
#(
  parameter  int ALGN_DATA_WIDTH   = 32,
  localparam int ALGN_OFFSET_WIDTH = offset_width(ALGN_DATA_WIDTH),
  localparam int ALGN_SIZE_WIDTH   = size_width(ALGN_DATA_WIDTH),
  localparam int FIFO_WIDTH        = fifo_width(ALGN_DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         pop_valid,
  input  logic [FIFO_WIDTH-1:0]        pop_data,
  output logic                         pop_ready,
  output logic                         md_tx_valid,
  output logic [ALGN_DATA_WIDTH-1:0]   md_tx_data,
  output logic [ALGN_OFFSET_WIDTH-1:0] md_tx_offset,
  output logic [ALGN_SIZE_WIDTH-1:0]   md_tx_size,
  input  logic                         md_tx_ready,
  input  logic                         md_tx_err,
  input  logic                         cnt_clr,
  output logic [15:0]                  tx_pkt_cnt,
  output logic [15:0]                  tx_err_cnt,
  output logic [15:0]                  drop_cnt,
  output logic                         irq_tx_err,
  output logic                         busy
);

  localparam int unsigned BYTES = ALGN_DATA_WIDTH / 8;
  localparam int EW       = ALGN_SIZE_WIDTH + 1;
  localparam int OFF_LSB  = offset_lsb(ALGN_DATA_WIDTH);
  localparam int OFF_MSB  = offset_msb(ALGN_DATA_WIDTH);
  localparam int SIZE_LSB = size_lsb(ALGN_DATA_WIDTH);
  localparam int SIZE_MSB = size_msb(ALGN_DATA_WIDTH);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [FIFO_WIDTH-1:0] out_q, out_d;
  logic [FIFO_WIDTH-1:0] skid_q, skid_d;
  logic                  pop_ready_q;
  logic                  irq_q;

  logic [ALGN_OFFSET_WIDTH-1:0] pop_offset;
  logic [ALGN_SIZE_WIDTH-1:0]   pop_size;
  logic [EW-1:0]                end_byte;
  logic                         entry_ok;
  logic                         pop_xfer, pop_legal, pop_drop, md_xfer;

  assign pop_offset = pop_data[OFF_MSB:OFF_LSB];
  assign pop_size   = pop_data[SIZE_MSB:SIZE_LSB];
  // One bit wider than size so offset+size can never wrap into a legal value
  assign end_byte   = {1'b0, pop_size} + {{(EW - ALGN_OFFSET_WIDTH){1'b0}}, pop_offset};
  assign entry_ok   = entry_legal(32'(pop_size), 32'(end_byte), BYTES);

  assign pop_xfer  = pop_valid && pop_ready_q;
  assign pop_legal = pop_xfer && entry_ok;
  assign pop_drop  = pop_xfer && !entry_ok;
  assign md_xfer   = md_tx_valid && md_tx_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (pop_legal) begin
          out_d   = pop_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (md_xfer && pop_legal) begin
          out_d = pop_data;
        end else if (md_xfer) begin
          state_d = ST_EMPTY;
        end else if (pop_legal) begin
          skid_d  = pop_data;
          state_d = ST_TWO;
        end
      end
      ST_TWO: begin
        if (md_xfer) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      pop_ready_q <= 1'b1;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      pop_ready_q <= (state_d != ST_TWO);
      irq_q       <= md_xfer && md_tx_err;
    end
  end

  assign pop_ready    = pop_ready_q;
  assign md_tx_valid  = (state_q != ST_EMPTY);
  assign busy         = (state_q != ST_EMPTY);
  assign md_tx_data   = out_q[ALGN_DATA_WIDTH-1:0];
  assign md_tx_offset = out_q[OFF_MSB:OFF_LSB];
  assign md_tx_size   = out_q[SIZE_MSB:SIZE_LSB];
  assign irq_tx_err   = irq_q;

  // Counter slots: 0 = completed transfers, 1 = errored transfers, 2 = drops
  logic [2:0]  cnt_inc;
  logic [15:0] cnt_val [3];

  assign cnt_inc = {pop_drop, md_xfer && md_tx_err, md_xfer};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      cfs_sat_cnt #(.WIDTH(16)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (cnt_inc[gi]),
        .clr     (cnt_clr),
        .value   (cnt_val[gi])
      );
    end
  endgenerate

  assign tx_pkt_cnt = cnt_val[0];
  assign tx_err_cnt = cnt_val[1];
  assign drop_cnt   = cnt_val[2];

endmodule

// File: tb/tb_cfs_md_tx_ctrl.sv
// Bench for cfs_md_tx_ctrl: queue-based occupancy/ordering model checked every
// cycle, plus directed cases with literal expectations.
module tb_cfs_md_tx_ctrl;

  localparam int DW = 32;
  localparam int OW = 2;
  localparam int SW = 3;
  localparam int FW = 37;

  logic          clk;
  logic          reset_n;
  logic          pop_valid;
  logic [FW-1:0] pop_data;
  logic          pop_ready;
  logic          md_tx_valid;
  logic [DW-1:0] md_tx_data;
  logic [OW-1:0] md_tx_offset;
  logic [SW-1:0] md_tx_size;
  logic          md_tx_ready;
  logic          md_tx_err;
  logic          cnt_clr;
  logic [15:0]   tx_pkt_cnt;
  logic [15:0]   tx_err_cnt;
  logic [15:0]   drop_cnt;
  logic          irq_tx_err;
  logic          busy;

  cfs_md_tx_ctrl #(.ALGN_DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pop_valid    (pop_valid),
    .pop_data     (pop_data),
    .pop_ready    (pop_ready),
    .md_tx_valid  (md_tx_valid),
    .md_tx_data   (md_tx_data),
    .md_tx_offset (md_tx_offset),
    .md_tx_size   (md_tx_size),
    .md_tx_ready  (md_tx_ready),
    .md_tx_err    (md_tx_err),
    .cnt_clr      (cnt_clr),
    .tx_pkt_cnt   (tx_pkt_cnt),
    .tx_err_cnt   (tx_err_cnt),
    .drop_cnt     (drop_cnt),
    .irq_tx_err   (irq_tx_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          off;
    int          size;
  } pkt_t;

  pkt_t exp_q[$];
  int   exp_pkt;
  int   exp_err;
  int   exp_drop;
  bit   exp_irq;
  int   n_cmp;
  int   n_bad;
  bit   quiet;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int size, input int off, input logic [31:0] d);
    logic [SW-1:0] s;
    logic [OW-1:0] o;
    s = SW'(size);
    o = OW'(off);
    return {s, o, d};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 16'hFFFF) ? 16'hFFFF : v + 1;
  endfunction

  // Reference model: buffer holds in-flight packets in order; at most two.
  always @(negedge clk) begin
    bit          ev, er, md, pop, legal;
    int          sz, off;
    logic [31:0] d;
    pkt_t        p;
    if (!reset_n) begin
      exp_q.delete();
      exp_pkt  = 0;
      exp_err  = 0;
      exp_drop = 0;
      exp_irq  = 0;
      check("rst_pop_ready", 64'(pop_ready), 64'(1));
      check("rst_valid", 64'(md_tx_valid), 64'(0));
      check("rst_data", 64'(md_tx_data), 64'(0));
      check("rst_offset", 64'(md_tx_offset), 64'(0));
      check("rst_size", 64'(md_tx_size), 64'(0));
      check("rst_pkt_cnt", 64'(tx_pkt_cnt), 64'(0));
      check("rst_err_cnt", 64'(tx_err_cnt), 64'(0));
      check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
      check("rst_irq", 64'(irq_tx_err), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
    end else begin
      ev = (exp_q.size() != 0);
      er = (exp_q.size() < 2);
      check("md_tx_valid", 64'(md_tx_valid), 64'(ev));
      check("busy", 64'(busy), 64'(ev));
      check("pop_ready", 64'(pop_ready), 64'(er));
      if (ev) begin
        check("md_tx_data", 64'(md_tx_data), 64'(exp_q[0].data));
        check("md_tx_offset", 64'(md_tx_offset), 64'(exp_q[0].off));
        check("md_tx_size", 64'(md_tx_size), 64'(exp_q[0].size));
      end
      check("tx_pkt_cnt", 64'(tx_pkt_cnt), 64'(exp_pkt));
      check("tx_err_cnt", 64'(tx_err_cnt), 64'(exp_err));
      check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      check("irq_tx_err", 64'(irq_tx_err), 64'(exp_irq));

      md  = ev && md_tx_ready;
      pop = pop_valid && er;
      sz  = int'(pop_data[36:34]);
      off = int'(pop_data[33:32]);
      d   = pop_data[31:0];
      legal = (sz != 0) && (off + sz <= DW / 8);

      exp_irq = md && md_tx_err;
      if (cnt_clr) begin
        exp_pkt  = 0;
        exp_err  = 0;
        exp_drop = 0;
      end else begin
        if (md) exp_pkt = sat_inc(exp_pkt);
        if (md && md_tx_err) exp_err = sat_inc(exp_err);
        if (pop && !legal) exp_drop = sat_inc(exp_drop);
      end
      if (md) begin
        if (!quiet)
          $display("md xfer data=%08h off=%0d size=%0d err=%0b",
                   exp_q[0].data, exp_q[0].off, exp_q[0].size, md_tx_err);
        void'(exp_q.pop_front());
      end
      if (pop) begin
        if (legal) begin
          p.data = d;
          p.off  = off;
          p.size = sz;
          exp_q.push_back(p);
        end else if (!quiet) begin
          $display("drop entry off=%0d size=%0d", off, sz);
        end
      end
    end
  end

  task automatic drive(input bit pv, input logic [FW-1:0] pd, input bit rdy,
                       input bit err, input bit clr);
    @(posedge clk);
    #1;
    pop_valid   = pv;
    pop_data    = pv ? pd : '0;
    md_tx_ready = rdy;
    md_tx_err   = err;
    cnt_clr     = clr;
  endtask

  function automatic logic [FW-1:0] rand_entry();
    int s, o;
    if ($urandom_range(0, 3) != 0) begin
      s = $urandom_range(1, 4);
      o = $urandom_range(0, 4 - s);
    end else begin
      s = $urandom_range(0, 7);
      o = $urandom_range(0, 3);
    end
    return mk(s, o, $urandom);
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    quiet = 0;
    reset_n     = 1'b0;
    pop_valid   = 1'b0;
    pop_data    = '0;
    md_tx_ready = 1'b0;
    md_tx_err   = 1'b0;
    cnt_clr     = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single packet: valid one cycle after the pop edge, for one cycle
    drive(1, mk(4, 0, 32'hAABBCCDD), 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    check("t1_valid", 64'(md_tx_valid), 64'(1));
    check("t1_data", 64'(md_tx_data), 64'h0000_0000_AABB_CCDD);
    drive(0, '0, 1, 0, 0);
    check("t1_valid_low", 64'(md_tx_valid), 64'(0));
    check("t1_pkt_cnt", 64'(tx_pkt_cnt), 64'(1));
    check("t1_busy", 64'(busy), 64'(0));

    // Back-to-back at full rate
    for (int i = 0; i < 3; i++) drive(1, mk(4, 0, 32'h1000 + i), 1, 0, 0);
    repeat (3) drive(0, '0, 1, 0, 0);

    // Back-pressure fills output and skid registers
    for (int i = 0; i < 5; i++) drive(1, mk(2, 1, 32'h2000 + i), 0, 0, 0);
    drive(0, '0, 1, 0, 0);
    check("t3_pop_ready", 64'(pop_ready), 64'(0));
    check("t3_busy", 64'(busy), 64'(1));
    check("t3_data_first", 64'(md_tx_data), 64'h2000);
    repeat (3) drive(0, '0, 1, 0, 0);
    check("t3_drained", 64'(busy), 64'(0));

    // Illegal entries are consumed and counted
    drive(1, mk(0, 0, 32'h1234), 1, 0, 0);
    drive(1, mk(2, 3, 32'h5678), 1, 0, 0);
    repeat (2) drive(0, '0, 1, 0, 0);
    check("t4_drop_cnt", 64'(drop_cnt), 64'(2));

    // Error only counts on a completing transfer
    drive(1, mk(1, 2, 32'hE0E0), 0, 1, 0);
    drive(0, '0, 0, 1, 0);
    drive(0, '0, 0, 1, 0);
    drive(0, '0, 1, 1, 0);
    drive(0, '0, 1, 0, 0);
    check("t5_irq", 64'(irq_tx_err), 64'(1));
    check("t5_err_cnt", 64'(tx_err_cnt), 64'(1));
    drive(0, '0, 1, 0, 0);
    check("t5_irq_pulse", 64'(irq_tx_err), 64'(0));

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, rand_entry(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
    repeat (3) drive(0, '0, 1, 0, 0);

    // Saturation of the transfer counter
    quiet = 1;
    drive(0, '0, 1, 0, 1);
    for (int i = 0; i < 65540; i++) drive(1, mk(4, 0, 32'(i)), 1, 0, 0);
    repeat (2) drive(0, '0, 1, 0, 0);
    quiet = 0;
    check("t6_sat", 64'(tx_pkt_cnt), 64'hFFFF);
    drive(1, mk(3, 1, 32'hCAFE), 1, 0, 0);
    repeat (2) drive(0, '0, 1, 0, 0);
    check("t6_sat_hold", 64'(tx_pkt_cnt), 64'hFFFF);

    // Clear wins over a simultaneous increment
    drive(1, mk(4, 0, 32'hC1EA), 1, 0, 0);
    drive(0, '0, 1, 0, 1);
    drive(0, '0, 1, 0, 0);
    check("t7_clr_wins", 64'(tx_pkt_cnt), 64'(0));

    // Asynchronous reset while two packets are buffered
    drive(1, mk(4, 0, 32'hDEAD0001), 0, 0, 0);
    drive(1, mk(4, 0, 32'hDEAD0002), 0, 0, 0);
    drive(0, '0, 0, 0, 0);
    check("t8_full", 64'(pop_ready), 64'(0));
    #1 reset_n = 1'b0;
    #1;
    check("t8_rst_valid", 64'(md_tx_valid), 64'(0));
    check("t8_rst_ready", 64'(pop_ready), 64'(1));
    check("t8_rst_busy", 64'(busy), 64'(0));
    check("t8_rst_data", 64'(md_tx_data), 64'(0));
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    #1 reset_n = 1'b1;
    repeat (4) drive(0, '0, 1, 0, 0);
    check("t8_no_ghost", 64'(tx_pkt_cnt), 64'(0));

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
